// File: rtl/video_capture_writer.sv
// video_capture_writer: samples the raster pixel stream and writes captured
// pixels into a ring line-buffer RAM. The capture window is set by a config
// that is shadowed at each frame start. The block also emits a one-shot start
// trigger per frame for the read side.
//
// Ports:
//   clock, reset            pixel clock, async active-high reset
//   pixel_valid             counters/pixel valid this cycle
//   R, G, B                 pixel colour channels
//   counterX, counterY      raster position
//   cfg_*                   capture/ring/trigger config, latched at frame start
//   wrdata, wraddr, wren    RAM write port (1-cycle latency from the pixel)
//   starttrigger            one-cycle start pulse, coincident with a write
//   line_count              lines captured in the current frame (saturating)
//   wrap_sticky             ring base wrapped since the last frame start
module video_capture_writer #(
    parameter int unsigned COLOR_BITS     = 8,
    parameter int unsigned CNT_WIDTH      = 12,
    parameter int unsigned ADDR_WIDTH     = 14,
    parameter int unsigned LINE_CNT_WIDTH = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      pixel_valid,
    input  logic [COLOR_BITS-1:0]     R,
    input  logic [COLOR_BITS-1:0]     G,
    input  logic [COLOR_BITS-1:0]     B,
    input  logic [CNT_WIDTH-1:0]      counterX,
    input  logic [CNT_WIDTH-1:0]      counterY,
    input  logic [CNT_WIDTH-1:0]      cfg_h_start,
    input  logic [CNT_WIDTH-1:0]      cfg_h_end,
    input  logic [CNT_WIDTH-1:0]      cfg_v_start,
    input  logic [CNT_WIDTH-1:0]      cfg_v_end,
    input  logic                      cfg_gap_en,
    input  logic [CNT_WIDTH-1:0]      cfg_gap_start,
    input  logic [CNT_WIDTH-1:0]      cfg_gap_end,
    input  logic                      cfg_hdecim,
    input  logic [ADDR_WIDTH-1:0]     cfg_line_length,
    input  logic [ADDR_WIDTH:0]       cfg_ram_numwords,
    input  logic                      cfg_frame_align,
    input  logic [ADDR_WIDTH-1:0]     cfg_trigger_addr,
    input  logic [LINE_CNT_WIDTH-1:0] cfg_trigger_lines,
    output logic [3*COLOR_BITS-1:0]   wrdata,
    output logic [ADDR_WIDTH-1:0]     wraddr,
    output logic                      wren,
    output logic                      starttrigger,
    output logic [LINE_CNT_WIDTH-1:0] line_count,
    output logic                      wrap_sticky
);

    localparam int unsigned NW_W = ADDR_WIDTH + 1;

    // Shadow config, active for the whole frame
    logic [CNT_WIDTH-1:0]      sh_h_start, sh_h_end, sh_v_start, sh_v_end;
    logic                      sh_gap_en;
    logic [CNT_WIDTH-1:0]      sh_gap_start, sh_gap_end;
    logic                      sh_hdecim;
    logic [ADDR_WIDTH-1:0]     sh_line_length;
    logic [NW_W-1:0]           sh_numwords;
    logic [ADDR_WIDTH-1:0]     sh_trigger_addr;
    logic [LINE_CNT_WIDTH-1:0] sh_trigger_lines;

    logic [ADDR_WIDTH-1:0]     base;
    logic                      armed;
    logic [CNT_WIDTH-1:0]      prev_x;

    logic                      frame_start_c;
    logic                      v_cap_c;
    logic                      h_cap_c;
    logic                      capture_c;
    logic                      eol_c;
    logic                      fire_c;
    logic [CNT_WIDTH-1:0]      h_off_c;
    logic [CNT_WIDTH-1:0]      h_idx_c;
    logic [ADDR_WIDTH-1:0]     addr_c;
    logic [ADDR_WIDTH-1:0]     base_next_c;
    logic                      wrap_next_c;

    // Window qualification and write address against the current shadows
    always_comb begin
        frame_start_c = pixel_valid && (counterX == '0) && (counterY == '0);
        v_cap_c       = (counterY >= sh_v_start) && (counterY < sh_v_end)
                        && !(sh_gap_en && (counterY >= sh_gap_start) && (counterY < sh_gap_end));
        h_off_c       = counterX - sh_h_start;
        h_cap_c       = (counterX >= sh_h_start) && (counterX < sh_h_end)
                        && (!sh_hdecim || !h_off_c[0]);
        capture_c     = pixel_valid && v_cap_c && h_cap_c;
        h_idx_c       = sh_hdecim ? (h_off_c >> 1) : h_off_c;
        addr_c        = base + ADDR_WIDTH'(h_idx_c);
        // Only the first valid h_end of a run ends the line
        eol_c         = pixel_valid && (counterX == sh_h_end) && (prev_x != sh_h_end);
        fire_c        = capture_c && armed && (line_count < sh_trigger_lines)
                        && (addr_c == sh_trigger_addr);
    end

    // Ring advance: wrap to 0 once the next slot would not fit
    always_comb begin
        base_next_c = base;
        wrap_next_c = 1'b0;
        if (NW_W'(base) < (sh_numwords - NW_W'(sh_line_length))) begin
            base_next_c = base + sh_line_length;
        end else begin
            base_next_c = '0;
            wrap_next_c = 1'b1;
        end
    end

    // Config shadow registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_h_start       <= '0;
            sh_h_end         <= '0;
            sh_v_start       <= '0;
            sh_v_end         <= '0;
            sh_gap_en        <= 1'b0;
            sh_gap_start     <= '0;
            sh_gap_end       <= '0;
            sh_hdecim        <= 1'b0;
            sh_line_length   <= '0;
            sh_numwords      <= '0;
            sh_trigger_addr  <= '0;
            sh_trigger_lines <= '0;
        end else if (frame_start_c) begin
            sh_h_start       <= cfg_h_start;
            sh_h_end         <= cfg_h_end;
            sh_v_start       <= cfg_v_start;
            sh_v_end         <= cfg_v_end;
            sh_gap_en        <= cfg_gap_en;
            sh_gap_start     <= cfg_gap_start;
            sh_gap_end       <= cfg_gap_end;
            sh_hdecim        <= cfg_hdecim;
            sh_line_length   <= cfg_line_length;
            sh_numwords      <= cfg_ram_numwords;
            sh_trigger_addr  <= cfg_trigger_addr;
            sh_trigger_lines <= cfg_trigger_lines;
        end
    end

    // Write port and trigger
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wren         <= 1'b0;
            starttrigger <= 1'b0;
            wrdata       <= '0;
            wraddr       <= '0;
        end else begin
            wren         <= capture_c;
            starttrigger <= fire_c;
            if (capture_c) begin
                wrdata <= {R, G, B};
                wraddr <= addr_c;
            end
        end
    end

    // Line/frame bookkeeping; frame start takes priority over end of line
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base        <= '0;
            armed       <= 1'b0;
            line_count  <= '0;
            wrap_sticky <= 1'b0;
            prev_x      <= '0;
        end else begin
            if (pixel_valid) begin
                prev_x <= counterX;
            end
            if (frame_start_c) begin
                line_count  <= '0;
                wrap_sticky <= 1'b0;
                armed       <= 1'b1;
                if (cfg_frame_align) begin
                    base <= '0;
                end
            end else begin
                if (fire_c) begin
                    armed <= 1'b0;
                end
                if (eol_c && v_cap_c) begin
                    base <= base_next_c;
                    if (wrap_next_c) begin
                        wrap_sticky <= 1'b1;
                    end
                    if (line_count != '1) begin
                        line_count <= line_count + LINE_CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_video_capture_writer.sv
// Bench for video_capture_writer: frame configs from a table, raster driven
// with random idle cycles, expected writes queued at drive time and compared
// when the DUT writes.
module tb_video_capture_writer;

    localparam int unsigned CB  = 8;
    localparam int unsigned CW  = 12;
    localparam int unsigned AW  = 14;
    localparam int unsigned LW  = 10;
    localparam int unsigned NWW = AW + 1;
    localparam int          W   = 16;

    logic          clock, reset, pixel_valid;
    logic [CB-1:0] R, G, B;
    logic [CW-1:0] counterX, counterY;
    logic [CW-1:0] cfg_h_start, cfg_h_end, cfg_v_start, cfg_v_end;
    logic          cfg_gap_en;
    logic [CW-1:0] cfg_gap_start, cfg_gap_end;
    logic          cfg_hdecim;
    logic [AW-1:0] cfg_line_length;
    logic [AW:0]   cfg_ram_numwords;
    logic          cfg_frame_align;
    logic [AW-1:0] cfg_trigger_addr;
    logic [LW-1:0] cfg_trigger_lines;
    logic [3*CB-1:0] wrdata;
    logic [AW-1:0] wraddr;
    logic          wren, starttrigger, wrap_sticky;
    logic [LW-1:0] line_count;

    video_capture_writer #(
        .COLOR_BITS(CB), .CNT_WIDTH(CW), .ADDR_WIDTH(AW), .LINE_CNT_WIDTH(LW)
    ) dut (
        .clock(clock), .reset(reset), .pixel_valid(pixel_valid),
        .R(R), .G(G), .B(B), .counterX(counterX), .counterY(counterY),
        .cfg_h_start(cfg_h_start), .cfg_h_end(cfg_h_end),
        .cfg_v_start(cfg_v_start), .cfg_v_end(cfg_v_end),
        .cfg_gap_en(cfg_gap_en), .cfg_gap_start(cfg_gap_start), .cfg_gap_end(cfg_gap_end),
        .cfg_hdecim(cfg_hdecim), .cfg_line_length(cfg_line_length),
        .cfg_ram_numwords(cfg_ram_numwords), .cfg_frame_align(cfg_frame_align),
        .cfg_trigger_addr(cfg_trigger_addr), .cfg_trigger_lines(cfg_trigger_lines),
        .wrdata(wrdata), .wraddr(wraddr), .wren(wren), .starttrigger(starttrigger),
        .line_count(line_count), .wrap_sticky(wrap_sticky)
    );

    typedef struct {
        logic [AW-1:0]   addr;
        logic [3*CB-1:0] data;
        logic            trig;
        int              edge_no;
    } exp_t;

    typedef struct {
        int hs, he, vs, ve;
        bit ge;
        int gs, gend;
        bit hd;
        int ll, nw, ta, tl, h;
        int exp_lines;
        bit exp_wrap;
        int exp_trigs;
    } row_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   trig_seen = 0;
    row_t rows[9];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Write monitor: every write must match the head of the scoreboard
    always @(negedge clock) begin : mon
        exp_t e;
        if (!reset) begin
            if (wren) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got addr=%0d data=%h trig=%0b", wraddr, wrdata, starttrigger);
                end else begin
                    e = sb.pop_front();
                    if (wraddr !== e.addr || wrdata !== e.data || starttrigger !== e.trig || cyc != e.edge_no) begin
                        errors++;
                        $display("FAIL write got addr=%0d data=%h trig=%0b cyc=%0d exp addr=%0d data=%h trig=%0b cyc=%0d",
                                 wraddr, wrdata, starttrigger, cyc, e.addr, e.data, e.trig, e.edge_no);
                    end
                end
                if (starttrigger) trig_seen++;
            end else begin
                checks++;
                if (starttrigger !== 1'b0) begin
                    errors++;
                    $display("FAIL trigger_without_write got starttrigger=%b exp 0", starttrigger);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic drive_px(input logic v, input int x, input int y);
        @(posedge clock);
        #1;
        pixel_valid = v;
        counterX    = CW'(x);
        counterY    = CW'(y);
        R           = CB'($urandom);
        G           = CB'($urandom);
        B           = CB'($urandom);
    endtask

    task automatic push_exp(input int addr, input logic trig);
        exp_t e;
        e.addr    = AW'(addr);
        e.data    = {R, G, B};
        e.trig    = trig;
        e.edge_no = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic set_cfg(input row_t t);
        cfg_h_start       = CW'(t.hs);
        cfg_h_end         = CW'(t.he);
        cfg_v_start       = CW'(t.vs);
        cfg_v_end         = CW'(t.ve);
        cfg_gap_en        = t.ge;
        cfg_gap_start     = CW'(t.gs);
        cfg_gap_end       = CW'(t.gend);
        cfg_hdecim        = t.hd;
        cfg_line_length   = AW'(t.ll);
        cfg_ram_numwords  = NWW'(t.nw);
        cfg_frame_align   = 1'b1;
        cfg_trigger_addr  = AW'(t.ta);
        cfg_trigger_lines = LW'(t.tl);
    endtask

    // Mid-frame config changes must have no effect
    task automatic scramble_cfg();
        cfg_h_start       = CW'($urandom_range(0, 15));
        cfg_h_end         = CW'($urandom_range(0, 15));
        cfg_v_start       = CW'($urandom_range(0, 7));
        cfg_v_end         = CW'($urandom_range(0, 7));
        cfg_gap_en        = 1'($urandom);
        cfg_gap_start     = CW'($urandom_range(0, 7));
        cfg_gap_end       = CW'($urandom_range(0, 7));
        cfg_hdecim        = 1'($urandom);
        cfg_line_length   = AW'($urandom_range(0, 31));
        cfg_ram_numwords  = NWW'($urandom_range(0, 127));
        cfg_frame_align   = 1'($urandom);
        cfg_trigger_addr  = AW'($urandom_range(0, 31));
        cfg_trigger_lines = LW'($urandom_range(0, 7));
    endtask

    // One frame starting at (0,0); stop_y >= 0 aborts mid-line at (stop_y, 12)
    task automatic run_frame(input row_t t, input int stop_y);
        int  k;
        bit  armed_b, vc, hc, trig;
        int  addr, reps;
        set_cfg(t);
        k = 0;
        armed_b = 1'b1;
        trig_seen = 0;
        for (int y = 0; y < t.h; y++) begin
            for (int x = 0; x < W; x++) begin
                if ($urandom_range(0, 4) == 0)
                    drive_px(1'b0, $urandom_range(0, 4095), $urandom_range(0, 15));
                vc = (y >= t.vs && y < t.ve) && !(t.ge && y >= t.gs && y < t.gend);
                hc = (x >= t.hs && x < t.he) && (!t.hd || ((x - t.hs) % 2 == 0));
                reps = (x == t.he) ? 2 : 1;
                for (int r = 0; r < reps; r++) begin
                    drive_px(1'b1, x, y);
                    if (y == 0 && x == 1 && r == 0) begin
                        check("frame_start_line_count", int'(line_count), 0);
                        check("frame_start_wrap", int'(wrap_sticky), 0);
                        scramble_cfg();
                    end
                    if (r == 0 && vc && hc && !(x == 0 && y == 0)) begin
                        addr = ((k * t.ll) % t.nw) + ((x - t.hs) >> t.hd);
                        trig = armed_b && (k < t.tl) && (addr == t.ta);
                        if (trig) armed_b = 1'b0;
                        push_exp(addr, trig);
                    end
                    if (y == stop_y && x == 12) return;
                end
                if (vc && x == t.he && !(x == 0 && y == 0)) k++;
            end
        end
        repeat (3) drive_px(1'b0, $urandom_range(0, 4095), $urandom_range(0, 15));
        check("pending_writes", sb.size(), 0);
        check("line_count", int'(line_count), t.exp_lines);
        check("wrap_sticky", int'(wrap_sticky), int'(t.exp_wrap));
        check("trigger_count", trig_seen, t.exp_trigs);
    endtask

    initial begin
        //          hs  he  vs  ve   ge gs   gend hd ll nw  ta tl h    lines wrap trigs
        rows[0] = '{10, 14, 2,  4,   0, 0,   0,   0, 8, 64, 0, 0, 6,   2,    0,   0};
        rows[1] = '{10, 14, 2,  4,   0, 0,   0,   1, 8, 64, 0, 0, 6,   2,    0,   0};
        rows[2] = '{10, 14, 0,  5,   0, 0,   0,   0, 8, 24, 0, 0, 6,   5,    1,   0};
        rows[3] = '{10, 14, 0,  500, 1, 240, 263, 0, 8, 64, 0, 0, 500, 477,  1,   0};
        rows[4] = '{10, 14, 0,  4,   0, 0,   0,   0, 8, 16, 9, 8, 4,   4,    1,   1};
        rows[5] = '{10, 14, 0,  4,   0, 0,   0,   0, 8, 16, 9, 8, 4,   4,    1,   1};
        rows[6] = '{10, 14, 0,  4,   0, 0,   0,   0, 8, 16, 9, 1, 4,   4,    1,   0};
        rows[7] = '{10, 14, 3,  3,   0, 0,   0,   0, 8, 64, 9, 8, 5,   0,    0,   0};
        rows[8] = '{10, 14, 0,  3,   0, 0,   0,   0, 0, 64, 2, 8, 4,   3,    0,   1};

        reset = 1'b1;
        pixel_valid = 1'b0;
        counterX = '0;
        counterY = '0;
        R = '0;
        G = '0;
        B = '0;
        set_cfg(rows[0]);
        #12;
        check("reset_wren", int'(wren), 0);
        check("reset_starttrigger", int'(starttrigger), 0);
        check("reset_wrdata", int'(wrdata), 0);
        check("reset_wraddr", int'(wraddr), 0);
        check("reset_line_count", int'(line_count), 0);
        check("reset_wrap", int'(wrap_sticky), 0);
        @(negedge clock);
        reset = 1'b0;

        // Empty window before the first frame start: no writes
        for (int x = 5; x < W; x++) drive_px(1'b1, x, 3);

        foreach (rows[i]) run_frame(rows[i], -1);

        // Reset in the middle of a captured line
        run_frame(rows[2], 2);
        check("pre_reset_wren", int'(wren), 1);
        check("pre_reset_line_count", int'(line_count), 2);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_wren", int'(wren), 0);
        check("async_reset_starttrigger", int'(starttrigger), 0);
        check("async_reset_line_count", int'(line_count), 0);
        sb.delete();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        set_cfg(rows[2]);
        for (int y = 2; y < 4; y++)
            for (int x = 1; x < W; x++) drive_px(1'b1, x, y);
        repeat (2) drive_px(1'b0, 0, 0);
        check("post_reset_line_count", int'(line_count), 0);
        check("post_reset_pending", sb.size(), 0);
        run_frame(rows[0], -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
